ppa_mp_add_seq: RTL
===================

// Module: ppa_mp_add_seq
// PURPOSE
//  Multi-precision add/subtract sequencer for the 16-bit Sklansky prefix adder.
//  Streams an N-word operand pair (LS word first) through one adder instance.
//  Chains carry between words; emits one result word per accepted input word.
//  Sits between a command/operand source and a result sink (e.g. a bignum ALU).
// PARAMETERS
//  WIDTH      16                      word width; fixed to the adder width, only 16 legal
//  MAX_WORDS  16                      max words per operation
//  CNT_W      $clog2(MAX_WORDS+1)     width of word count fields
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      command accepted when cmd_valid&&cmd_ready
//  cmd_words  in   CNT_W  word count; 0 treated as 1; >MAX_WORDS clamped to MAX_WORDS
//  cmd_sub    in   1      1: A-B, 0: A+B
//  cmd_cin    in   1      initial carry (add) / initial borrow (sub)
//  abort      in   1      synchronous abort of current operation
//  in_valid   in   1      operand word pair offered
//  in_ready   out  1      operand word pair accepted on in_valid&&in_ready
//  in_a       in   WIDTH  operand A word
//  in_b       in   WIDTH  operand B word
//  out_valid  out  1      result word valid
//  out_ready  in   1      sink accepts result on out_valid&&out_ready
//  out_sum    out  WIDTH  result word
//  out_last   out  1      result word is the final word of the operation
//  out_cout   out  1      final carry out (add) / NOT borrow (sub); valid with out_last
//  out_ovf    out  1      signed overflow of the full-width result; valid with out_last
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0;
//   carry=0, count=0. Reset takes effect mid-operation; partial results are discarded.
//  FSM states:
//   IDLE -> RUN on cmd fire.
//   RUN  -> DRAIN on the in fire of the last word.
//   DRAIN -> IDLE on the out fire of the last word.
//   Any state -> IDLE on abort.
//  cmd_ready = (state==IDLE). On cmd fire, latch the following:
//   - sub
//   - words (after the 0/clamp rule)
//   - carry = cmd_cin ^ cmd_sub (sub with cin=0 computes A-B)
//   - count = 0
//  in_ready = (state==RUN) && (!out_valid || out_ready); one-deep output register.
//  On in fire:
//   - b' = sub ? ~in_b : in_b
//   - adder(A=in_a, B=b', cin=carry) is registered into out_sum
//   - carry <= adder cout; count++
//   - out_valid=1; out_last = (count==words-1)
//   - on the last word, out_cout = adder cout and
//     out_ovf = (in_a[15]==b'[15]) && (sum[15]!=in_a[15])
//  Latency: 1 cycle from in fire to out_valid. Full throughput of 1 word/cycle
//   when out_ready is held high.
//  out_valid clears on out fire unless a new in fire happens in the same cycle;
//   a simultaneous in+out fire reloads the register.
//  out_sum/out_last/out_cout/out_ovf hold stable while out_valid && !out_ready.
//  abort has priority over all handshakes in its cycle:
//   - clears out_valid and out_last; returns to IDLE
//   - no in or out fire is counted in that cycle
//  abort in IDLE is a no-op; cmd_ready stays 1.
//  No carry/borrow propagates across operations; each command re-seeds the carry.
//  Count never wraps: words <= MAX_WORDS guaranteed by the clamp.
//  in_valid in IDLE/DRAIN is ignored (in_ready=0). cmd_valid outside IDLE is ignored.
// STRUCTURE
//  Package ppa_mp_pkg:
//   - state enum {IDLE, RUN, DRAIN}
//   - WORD_W=16 localparam
//   - clamp function for cmd_words
//  One sub-module: the existing PPA_Sklansky_16bit adder, instantiated once, purely
//   combinational. The sequencer adds the B-inversion, carry register, counter,
//   FSM and output register around it.
// TESTING
//  1. 2-word add 0x0001_FFFF + 0x0000_0001, cin=0
//     -> words 0x0000, 0x0002; out_cout=0; out_ovf=0.
//  2. 1-word sub 0x0000 - 0x0001, cin=0
//     -> 0xFFFF; out_cout=0 (borrow); out_ovf=0; out_last on the first word.
//  3. 1-word add 0x7FFF + 0x0001
//     -> 0x8000, out_ovf=1.
//     cmd_words=0 behaves as 1 word.
//  4. 4-word add with out_ready toggled 1/0 each cycle
//     -> no lost/duplicated word, outputs stable while stalled, in_ready low when full.
//  5. abort asserted in RUN after word 2 of 4, with a simultaneous in fire
//     -> out_valid=0 next cycle, cmd_ready=1, next op starts with a fresh carry.
//  6. rst_n low mid-DRAIN, deasserted
//     -> all outputs 0, cmd_ready=1; next 1-word add 0x0003+0x0004 gives 0x0007.

Source files
------------

// File: rtl/ppa_mp_pkg.sv
// Shared types, widths and helpers for the multi-precision add/subtract sequencer.
package ppa_mp_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A zero word count runs one word; oversized counts saturate at the maximum.
  function automatic int unsigned clamp_words(input int unsigned words,
                                              input int unsigned max_words);
    if (words == 0) begin
      return 1;
    end else if (words > max_words) begin
      return max_words;
    end else begin
      return words;
    end
  endfunction

endpackage

// File: rtl/ppa_mp_add_seq_if.sv
// Command, operand and result handshakes of the multi-precision add/subtract sequencer.
interface ppa_mp_add_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_words;
  logic             cmd_sub;
  logic             cmd_cin;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_last;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output cmd_valid, cmd_words, cmd_sub, cmd_cin, abort,
    output in_valid, in_a, in_b, out_ready,
    input  cmd_ready, in_ready, out_valid, out_sum, out_last, out_cout, out_ovf
  );

  modport slave (
    input  cmd_valid, cmd_words, cmd_sub, cmd_cin, abort,
    input  in_valid, in_a, in_b, out_ready,
    output cmd_ready, in_ready, out_valid, out_sum, out_last, out_cout, out_ovf
  );
endinterface

// File: rtl/PPA_Sklansky_16bit.sv
// 16-bit Sklansky parallel-prefix adder with carry in; purely combinational.
module PPA_Sklansky_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // One prefix level: bits with bit l of their index set absorb the group just below them.
  function automatic logic [31:0] sk_level(input logic [15:0] g, input logic [15:0] p,
                                           input int l);
    logic [15:0] gn;
    logic [15:0] pn;
    int          j;
    gn = g;
    pn = p;
    for (int i = 0; i < 16; i++) begin
      if (((i >> l) & 1) == 1) begin
        j     = ((i >> l) << l) - 1;
        gn[i] = g[i] | (p[i] & g[j]);
        pn[i] = p[i] & p[j];
      end
    end
    return {gn, pn};
  endfunction

  logic [15:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4;
  logic [15:0] gc;

  assign g0 = a & b;
  assign p0 = a ^ b;
  assign {g1, p1} = sk_level(g0, p0, 0);
  assign {g2, p2} = sk_level(g1, p1, 1);
  assign {g3, p3} = sk_level(g2, p2, 2);
  assign {g4, p4} = sk_level(g3, p3, 3);

  // gc[i] is the carry out of bit i with the incoming carry folded in.
  assign gc   = g4 | (p4 & {16{cin}});
  assign sum  = p0 ^ {gc[14:0], cin};
  assign cout = gc[15];

endmodule

// File: rtl/ppa_mp_add_seq.sv
// Streams N-word operand pairs through one Sklansky adder, chaining carry between words.
module ppa_mp_add_seq
  import ppa_mp_pkg::*;
#(
  parameter int unsigned WIDTH     = WORD_W,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input logic            clk,
  input logic            rst_n,
  ppa_mp_add_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]       state_q, state_d;
  logic             sub_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] count_q;
  logic             carry_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_last_q;
  logic             out_cout_q;
  logic             out_ovf_q;

  logic             cmd_fire;
  logic             in_fire;
  logic             out_fire;
  logic             is_last;
  logic [CNT_W-1:0] words_clamped;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.in_ready  = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

  // abort suppresses operand and result transfers; a command in IDLE is unaffected.
  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign in_fire  = bus.in_valid && bus.in_ready && !bus.abort;
  assign out_fire = out_valid_q && bus.out_ready && !bus.abort;

  assign words_clamped = CNT_W'(clamp_words(32'(bus.cmd_words), MAX_WORDS));
  assign is_last       = (count_q == words_q - CNT_W'(1));

  assign b_eff   = sub_q ? ~bus.in_b : bus.in_b;
  assign add_ovf = (bus.in_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != bus.in_a[WIDTH-1]);

  PPA_Sklansky_16bit u_adder (
    .a    (bus.in_a),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_fire) state_d = ST_RUN;
      ST_RUN:   if (in_fire && is_last) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire && out_last_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sub_q   <= 1'b0;
      words_q <= CNT_W'(1);
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        sub_q   <= bus.cmd_sub;
        words_q <= words_clamped;
        carry_q <= bus.cmd_cin ^ bus.cmd_sub;
        count_q <= '0;
      end else if (in_fire) begin
        carry_q <= add_cout;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // One-deep result register; a simultaneous in and out fire reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (bus.abort) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= add_sum;
      out_last_q  <= is_last;
      out_cout_q  <= is_last && add_cout;
      out_ovf_q   <= is_last && add_ovf;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
